// File: rtl/fetch_resp_queue.sv
// Fetch response queue between imem and the F/D boundary: tracks outstanding requests,
// buffers responses, and discards in-flight responses after a squash.
// Optional same-cycle bypass when the buffer is empty: define FETCH_RESP_QUEUE_BYPASS_EN.
module fetch_resp_queue #(
  parameter int unsigned p_max_inflight = 2,
  parameter int unsigned p_num_entries  = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  freq_val,
  output logic                                  freq_rdy,
  input  logic [31:0]                           freq_addr,
  output logic                                  imemreq_val,
  input  logic                                  imemreq_rdy,
  output logic [31:0]                           imemreq_addr,
  input  logic                                  imemresp_val,
  output logic                                  imemresp_rdy,
  input  logic [31:0]                           imemresp_data,
  output logic                                  fresp_val,
  input  logic                                  fresp_rdy,
  output logic [31:0]                           fresp_data,
  input  logic                                  squash,
  output logic [$clog2(p_max_inflight+1)-1:0]   inflight
);

  localparam int unsigned IW = $clog2(p_max_inflight + 1);
  localparam int unsigned PW = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam int unsigned CW = $clog2(p_num_entries + 1);
  localparam int unsigned DW = 32;

  logic [IW-1:0] inflight_q, inflight_d;
  logic [IW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [DW-1:0] mem_q [p_num_entries];
  logic [DW-1:0] mem_d [p_num_entries];

  logic full;
  logic drop_mode;
  logic fifo_empty;
  logic fifo_full;
  logic req_fire;
  logic resp_fire;
  logic bypass;
  logic enq;
  logic deq;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(p_num_entries - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake and datapath steering; fifo_full comes from the count register only.
  always_comb begin
    full         = (inflight_q == IW'(p_max_inflight));
    drop_mode    = (drop_cnt_q != '0);
    fifo_empty   = (cnt_q == '0);
    fifo_full    = (cnt_q == CW'(p_num_entries));

    imemreq_val  = freq_val & ~full;
    freq_rdy     = imemreq_rdy & ~full;
    imemreq_addr = freq_addr;
    req_fire     = freq_val & freq_rdy;

    imemresp_rdy = drop_mode | squash | ~fifo_full;
    resp_fire    = imemresp_val & imemresp_rdy;

`ifdef FETCH_RESP_QUEUE_BYPASS_EN
    bypass       = fifo_empty & ~drop_mode & ~squash & fresp_rdy & imemresp_val;
    fresp_data   = fifo_empty ? imemresp_data : mem_q[head_q];
`else
    bypass       = 1'b0;
    fresp_data   = mem_q[head_q];
`endif
    fresp_val    = (~fifo_empty & ~squash) | bypass;

    enq          = resp_fire & ~drop_mode & ~squash & ~bypass;
    deq          = ~fifo_empty & fresp_rdy & ~squash;
    inflight     = inflight_q;
  end

  // Next-state for counters and FIFO; squash flushes and re-arms the drop counter.
  always_comb begin
    inflight_d = inflight_q + IW'(req_fire) - IW'(resp_fire);
    drop_cnt_d = drop_cnt_q;
    cnt_d      = cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    mem_d      = mem_q;

    if (squash) begin
      drop_cnt_d = inflight_q - IW'(resp_fire);
      cnt_d      = '0;
      head_d     = tail_q;
    end else begin
      if (drop_mode && resp_fire) begin
        drop_cnt_d = drop_cnt_q - IW'(1);
      end
      if (enq) begin
        mem_d[tail_q] = imemresp_data;
        tail_d        = ptr_inc(tail_q);
      end
      if (deq) begin
        head_d = ptr_inc(head_q);
      end
      cnt_d = cnt_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= '0;
      drop_cnt_q <= '0;
      cnt_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      for (int i = 0; i < int'(p_num_entries); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      mem_q      <= mem_d;
    end
  end

  // imem must never answer more requests than were issued.
  a_resp_has_req: assert property (@(posedge clk) disable iff (!reset)
    resp_fire |-> (inflight_q != '0));
  a_drop_le_inflight: assert property (@(posedge clk) disable iff (!reset)
    drop_cnt_q <= inflight_q);
  a_inflight_bound: assert property (@(posedge clk) disable iff (!reset)
    inflight_q <= IW'(p_max_inflight));

endmodule

// File: tb/tb_fetch_resp_queue.sv
// Randomized + directed bench for fetch_resp_queue with an in-order imem model,
// a request-level reference model and a scoreboard of instructions owed to D.
module tb_fetch_resp_queue;

  localparam int unsigned MAX = 2;
  localparam int unsigned NE  = 2;
  localparam int unsigned IW  = $clog2(MAX + 1);

  logic          clk;
  logic          reset;
  logic          freq_val;
  logic          freq_rdy;
  logic [31:0]   freq_addr;
  logic          imemreq_val;
  logic          imemreq_rdy;
  logic [31:0]   imemreq_addr;
  logic          imemresp_val;
  logic          imemresp_rdy;
  logic [31:0]   imemresp_data;
  logic          fresp_val;
  logic          fresp_rdy;
  logic [31:0]   fresp_data;
  logic          squash;
  logic [IW-1:0] inflight;

  fetch_resp_queue #(.p_max_inflight(MAX), .p_num_entries(NE)) dut (
    .clk(clk), .reset(reset),
    .freq_val(freq_val), .freq_rdy(freq_rdy), .freq_addr(freq_addr),
    .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy), .imemreq_addr(imemreq_addr),
    .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy), .imemresp_data(imemresp_data),
    .fresp_val(fresp_val), .fresp_rdy(fresp_rdy), .fresp_data(fresp_data),
    .squash(squash), .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outstanding requests in issue order; live=0 means a squash has orphaned it.
  typedef struct {
    logic [31:0] data;
    bit          live;
  } req_t;

  req_t        out_q[$];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] imem_data(input logic [31:0] a);
    case (a)
      32'h0000_0200: return 32'h0000_0013;
      32'h0000_0204: return 32'h0010_0093;
      32'h0000_0300: return 32'hDEAD_BEEF;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs to the model state at the falling edge.
  always @(negedge clk) begin
    int n;
    bit dropm;
    bit byp;
    if (reset) begin
      n     = out_q.size();
      dropm = (n > 0) && !out_q[0].live;
      byp   = 1'b0;
`ifdef FETCH_RESP_QUEUE_BYPASS_EN
      byp   = (exp_q.size() == 0) && (n > 0) && out_q[0].live && !squash && fresp_rdy && imemresp_val;
`endif
      chk("inflight", 32'(inflight), 32'(n));
      chk("freq_rdy", 32'(freq_rdy), 32'(imemreq_rdy && (n < int'(MAX))));
      chk("imemreq_val", 32'(imemreq_val), 32'(freq_val && (n < int'(MAX))));
      chk("imemreq_addr", imemreq_addr, freq_addr);
      chk("imemresp_rdy", 32'(imemresp_rdy), 32'(dropm || squash || (exp_q.size() < int'(NE))));
      chk("fresp_val", 32'(fresp_val), 32'(((exp_q.size() > 0) && !squash) || byp));
      if (byp)
        chk("fresp_data_bypass", fresp_data, out_q[0].data);
      else if ((exp_q.size() > 0) && !squash && fresp_rdy)
        chk("fresp_data", fresp_data, exp_q[0]);
    end
  end

  // Reference model: advances on the handshakes implied by the spec rules.
  always @(negedge clk) begin
    int   pre;
    int   n;
    bit   dropm;
    bit   rf;
    bit   qf;
    bit   byp;
    req_t e;
    #2;
    if (!reset) begin
      out_q.delete();
      exp_q.delete();
    end else begin
      pre   = exp_q.size();
      n     = out_q.size();
      dropm = (n > 0) && !out_q[0].live;
      rf    = imemresp_val && (n > 0) && (dropm || squash || (pre < int'(NE)));
      qf    = freq_val && imemreq_rdy && (n < int'(MAX));
      byp   = 1'b0;
`ifdef FETCH_RESP_QUEUE_BYPASS_EN
      byp   = (pre == 0) && (n > 0) && out_q[0].live && !squash && fresp_rdy && imemresp_val;
`endif
      if ((pre > 0) && !squash && fresp_rdy) void'(exp_q.pop_front());
      if (rf) begin
        e = out_q.pop_front();
        if (e.live && !squash && !byp) exp_q.push_back(e.data);
      end
      if (squash) begin
        exp_q.delete();
        foreach (out_q[i]) out_q[i].live = 1'b0;
      end
      if (qf) out_q.push_back('{data: imem_data(freq_addr), live: 1'b1});
    end
  end

  // One cycle of stimulus; called at posedge+1. imem answers in order from out_q.
  task automatic drive(input bit fv, input logic [31:0] a, input bit ir,
                       input bit rv, input bit fr, input bit sq);
    freq_val      = fv;
    freq_addr     = a;
    imemreq_rdy   = ir;
    imemresp_val  = rv && (out_q.size() > 0);
    imemresp_data = (out_q.size() > 0) ? out_q[0].data : $urandom;
    fresp_rdy     = fr;
    squash        = sq;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (out_q.size() > 0 || exp_q.size() > 0); i++)
      drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("drain_exp_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic basic_flow();
    drive(1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h204, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic rand_cycles(input int n, input int preq, input int pir,
                             input int presp, input int pfr, input int psq);
    for (int i = 0; i < n; i++)
      drive($urandom_range(99) < preq, $urandom & 32'hFFFF_FFFC,
            $urandom_range(99) < pir, $urandom_range(99) < presp,
            $urandom_range(99) < pfr, $urandom_range(99) < psq);
  endtask

  initial begin
    reset = 1'b0; freq_val = 1'b0; freq_addr = '0; imemreq_rdy = 1'b0;
    imemresp_val = 1'b0; imemresp_data = '0; fresp_rdy = 1'b0; squash = 1'b0;
    @(posedge clk); #1;
    chk("reset_inflight", 32'(inflight), 32'd0);
    chk("reset_fresp_val", 32'(fresp_val), 32'd0);
    chk("reset_imemresp_rdy", 32'(imemresp_rdy), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    basic_flow();

    // Inflight limit: third request waits until one response has returned.
    drive(1'b1, 32'h400, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h404, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h408, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("limit_blocked", 32'(freq_rdy), 32'd0);
    drive(1'b1, 32'h408, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 32'h408, 1'b1, 1'b0, 1'b1, 1'b0);
    drain();

    // Squash with two in flight; 0x300 belongs to the new stream.
    drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h104, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 32'h300, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b0);
    drain();

    // Squash coinciding with a response while the FIFO holds one entry.
    drive(1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h504, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b1);
    chk("coinc_fresp_val", 32'(fresp_val), 32'd0);
    chk("coinc_inflight", 32'(inflight), 32'd0);
    drive(1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b0);

    // Backpressure: FIFO fills, imem is stalled, then drains in order.
    drive(1'b1, 32'h600, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h604, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h608, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h608, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0);
    chk("bp_imemresp_rdy", 32'(imemresp_rdy), 32'd0);
    drive(1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0);
    drain();

    // Asynchronous reset with two in flight and a buffered instruction.
    drive(1'b1, 32'h700, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h704, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h708, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst_mid_inflight", 32'(inflight), 32'd0);
    chk("rst_mid_fresp_val", 32'(fresp_val), 32'd0);
    chk("rst_mid_imemresp_rdy", 32'(imemresp_rdy), 32'd1);
    freq_val = 1'b0; imemresp_val = 1'b0; squash = 1'b0; fresp_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    basic_flow();

    rand_cycles(1000, 60, 80, 60, 70, 5);
    rand_cycles(800, 90, 90, 80, 30, 3);
    rand_cycles(800, 40, 60, 90, 95, 10);
    rand_cycles(400, 90, 95, 95, 95, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
